// File: rtl/bitstream_pkg.sv
// Shared types and constants for the serial deserializer and its 1011 pattern detector.
package bitstream_pkg;

    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4
    } state_t;

    localparam logic [3:0] PAT      = 4'b1011;
    localparam logic [7:0] HCNT_MAX = 8'd255;

    // Next state of the overlapping 1011 matcher for one accepted bit.
    function automatic state_t fsm_next(input state_t s, input logic d);
        state_t n;
        n = S0;
        case (s)
            S0:      n = d ? S1 : S0;
            S1:      n = d ? S1 : S2;
            S2:      n = d ? S3 : S0;
            S3:      n = d ? S4 : S2;
            S4:      n = d ? S1 : S2;
            default: n = S0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/seq_fsm_1011.sv
// Moore detector for the overlapping pattern 1011 with a registered hit strobe
// and a saturating hit counter.
module seq_fsm_1011
    import bitstream_pkg::*;
(
    input  logic       CK,
    input  logic       RST_N,
    input  logic       CLR,
    input  logic       EN,
    input  logic       D,
    output logic       HIT,
    output logic [7:0] HCNT
);

    state_t state;
    state_t state_nxt;
    logic   hit_set;

    always_ff @(posedge CK or negedge RST_N) begin
        if (!RST_N) begin
            state <= S0;
        end else if (CLR) begin
            state <= S0;
        end else if (EN) begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        hit_set   = 1'b0;
        if (EN) begin
            state_nxt = fsm_next(state, D);
            hit_set   = (state_nxt == S4);
        end
    end

    always_ff @(posedge CK or negedge RST_N) begin
        if (!RST_N) begin
            HIT  <= 1'b0;
            HCNT <= '0;
        end else if (CLR) begin
            HIT  <= 1'b0;
            HCNT <= '0;
        end else begin
            HIT <= hit_set;
            if (hit_set && (HCNT != HCNT_MAX)) begin
                HCNT <= HCNT + 8'd1;
            end
        end
    end

endmodule

// File: rtl/bit_stream_deser.sv
// MSB-first serial-to-parallel packer with a one-cycle word strobe, alongside
// a 1011 pattern detector fed by the same accepted bits.
module bit_stream_deser
    import bitstream_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             CK,
    input  logic             RST_N,
    input  logic             D,
    input  logic             EN,
    input  logic             CLR,
    output logic [WIDTH-1:0] Q,
    output logic             QV,
    output logic             HIT,
    output logic [7:0]       HCNT
);

    localparam int BW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [BW-1:0] LAST = BW'(WIDTH - 1);

    // Only WIDTH-1 history bits are kept: the oldest bit of a word is never
    // needed after the word is delivered, so the top bit would be dead state.
    logic [WIDTH-2:0] sr;
    logic [BW-1:0]    bcnt;
    logic [WIDTH-1:0] shifted;

    assign shifted = {sr, D};

    always_ff @(posedge CK or negedge RST_N) begin
        if (!RST_N) begin
            sr   <= '0;
            bcnt <= '0;
            Q    <= '0;
            QV   <= 1'b0;
        end else if (CLR) begin
            sr   <= '0;
            bcnt <= '0;
            Q    <= '0;
            QV   <= 1'b0;
        end else begin
            QV <= 1'b0;
            if (EN) begin
                sr <= shifted[WIDTH-2:0];
                if (bcnt == LAST) begin
                    bcnt <= '0;
                    Q    <= shifted;
                    QV   <= 1'b1;
                end else begin
                    bcnt <= bcnt + 1'b1;
                end
            end
        end
    end

    seq_fsm_1011 u_fsm (
        .CK    (CK),
        .RST_N (RST_N),
        .CLR   (CLR),
        .EN    (EN),
        .D     (D),
        .HIT   (HIT),
        .HCNT  (HCNT)
    );

endmodule
